// File: rtl/egress_pkt_arbiter_n.sv
// egress_pkt_arbiter_n: N-input packet-atomic round-robin arbiter
// onto one registered Avalon-ST egress stream, with packet counters.
// Optional macro EGRESS_PRIO_EN: channel 0 gets strict priority.
// Ports: Clk, Rst (async, active-high); per-channel in_valid/in_ready,
//   in_data, in_sop, in_eop, in_empty; egress out_valid/out_ready,
//   out_data, out_sop, out_eop, out_empty; out_almostfull (gates new
//   grants only); in_pkt_cnt (per-channel eop count), out_pkt_cnt.
module egress_pkt_arbiter_n #(
  parameter int NUM_IN  = 5,
  parameter int DATA_W  = 512,
  parameter int EMPTY_W = 6,
  parameter int CNT_W   = 32
) (
  input  logic                      Clk,
  input  logic                      Rst,
  input  logic [NUM_IN-1:0]         in_valid,
  output logic [NUM_IN-1:0]         in_ready,
  input  logic [NUM_IN*DATA_W-1:0]  in_data,
  input  logic [NUM_IN-1:0]         in_sop,
  input  logic [NUM_IN-1:0]         in_eop,
  input  logic [NUM_IN*EMPTY_W-1:0] in_empty,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic                      out_sop,
  output logic                      out_eop,
  output logic [EMPTY_W-1:0]        out_empty,
  input  logic                      out_almostfull,
  output logic [NUM_IN*CNT_W-1:0]   in_pkt_cnt,
  output logic [CNT_W-1:0]          out_pkt_cnt
);

  localparam int PTR_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  typedef enum logic {IDLE, XFER} state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   grant_q, grant_d;

  logic               found;
  logic [PTR_W-1:0]   winner;
  logic [PTR_W-1:0]   idx;

  logic [DATA_W-1:0]  sel_data;
  logic               sel_sop;
  logic               sel_eop;
  logic [EMPTY_W-1:0] sel_empty;

  logic               rdy;
  logic               acc;

  logic               out_valid_q;
  logic [DATA_W-1:0]  out_data_q;
  logic               out_sop_q;
  logic               out_eop_q;
  logic [EMPTY_W-1:0] out_empty_q;

  logic [CNT_W-1:0]   in_cnt_q [NUM_IN];
  logic [CNT_W-1:0]   out_cnt_q;

  // Search starts one past the last winner and wraps, so the
  // most recently served channel is considered last.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int k = 1; k <= NUM_IN; k++) begin
      idx = PTR_W'((int'(ptr_q) + k) % NUM_IN);
      if (!found && in_valid[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  always_comb begin
    sel_data  = '0;
    sel_sop   = 1'b0;
    sel_eop   = 1'b0;
    sel_empty = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (grant_q == PTR_W'(i)) begin
        sel_data  = in_data[i*DATA_W +: DATA_W];
        sel_sop   = in_sop[i];
        sel_eop   = in_eop[i];
        sel_empty = in_empty[i*EMPTY_W +: EMPTY_W];
      end
    end
  end

  // Output slot is free if empty or being drained this cycle.
  assign rdy = !out_valid_q || out_ready;

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    ptr_d    = ptr_q;
    in_ready = '0;
    acc      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!out_almostfull && found) begin
          state_d = XFER;
`ifdef EGRESS_PRIO_EN
          // Priority wins leave the RR pointer untouched.
          if (in_valid[0]) begin
            grant_d = '0;
          end else begin
            grant_d = winner;
            ptr_d   = winner;
          end
`else
          grant_d = winner;
          ptr_d   = winner;
`endif
        end
      end
      XFER: begin
        in_ready[grant_q] = rdy;
        acc = in_valid[grant_q] && rdy;
        if (acc && sel_eop) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= PTR_W'(NUM_IN - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      out_empty_q <= '0;
    end else if (acc) begin
      out_valid_q <= 1'b1;
      out_data_q  <= sel_data;
      out_sop_q   <= sel_sop;
      out_eop_q   <= sel_eop;
      out_empty_q <= sel_empty;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      for (int i = 0; i < NUM_IN; i++) begin
        in_cnt_q[i] <= '0;
      end
      out_cnt_q <= '0;
    end else begin
      for (int i = 0; i < NUM_IN; i++) begin
        if (acc && sel_eop && grant_q == PTR_W'(i)) begin
          in_cnt_q[i] <= in_cnt_q[i] + CNT_W'(1);
        end
      end
      if (out_valid_q && out_ready && out_eop_q) begin
        out_cnt_q <= out_cnt_q + CNT_W'(1);
      end
    end
  end

  for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_cnt
    assign in_pkt_cnt[gi*CNT_W +: CNT_W] = in_cnt_q[gi];
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_sop     = out_sop_q;
  assign out_eop     = out_eop_q;
  assign out_empty   = out_empty_q;
  assign out_pkt_cnt = out_cnt_q;

endmodule

// File: tb/tb_egress_pkt_arbiter_n.sv
// tb_egress_pkt_arbiter_n: scoreboard bench for egress_pkt_arbiter_n.
// Per-channel beat queues feed the DUT; a monitor checks egress order.
module tb_egress_pkt_arbiter_n;
  localparam int N  = 5;
  localparam int DW = 32;
  localparam int EW = 2;
  localparam int CW = 32;

  logic            Clk = 1'b0;
  logic            Rst;
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_ready;
  logic [N*DW-1:0] in_data;
  logic [N-1:0]    in_sop;
  logic [N-1:0]    in_eop;
  logic [N*EW-1:0] in_empty;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_data;
  logic            out_sop;
  logic            out_eop;
  logic [EW-1:0]   out_empty;
  logic            out_almostfull;
  logic [N*CW-1:0] in_pkt_cnt;
  logic [CW-1:0]   out_pkt_cnt;

  egress_pkt_arbiter_n #(
    .NUM_IN(N), .DATA_W(DW), .EMPTY_W(EW), .CNT_W(CW)
  ) dut (
    .Clk(Clk), .Rst(Rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sop(in_sop),
    .in_eop(in_eop), .in_empty(in_empty),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sop(out_sop),
    .out_eop(out_eop), .out_empty(out_empty),
    .out_almostfull(out_almostfull),
    .in_pkt_cnt(in_pkt_cnt), .out_pkt_cnt(out_pkt_cnt)
  );

  typedef struct packed {
    logic [DW-1:0] d;
    logic          sop;
    logic          eop;
    logic [EW-1:0] e;
  } beat_t;

  beat_t    chq [N][$];
  beat_t    expq[$];
  int       log_cyc[$];
  int       checks = 0;
  int       errors = 0;
  int       cyc = 0;
  int       exp_in [N];
  int       exp_out = 0;
  int       pkt_id = 0;
  logic [N-1:0] hs;

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", nm, act, req);
    end
  endtask

  task automatic push_pkt(input int ch, input int nb);
    beat_t x;
    for (int b = 0; b < nb; b++) begin
      x.d   = {8'(ch), 8'(pkt_id), 16'(b)};
      x.sop = (b == 0);
      x.eop = (b == nb - 1);
      x.e   = x.eop ? EW'(pkt_id) : '0;
      chq[ch].push_back(x);
      expq.push_back(x);
    end
    pkt_id++;
    exp_in[ch]++;
    exp_out++;
  endtask

  task automatic drain();
    int n = 0;
    while (expq.size() > 0 && n < 1000) begin
      @(posedge Clk);
      n++;
    end
    if (expq.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout left=%0d", expq.size());
      expq.delete();
    end
    repeat (3) @(posedge Clk);
    #1;
  endtask

  task automatic check_cnt(input string tag);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("%s_in_cnt%0d", tag, i),
          in_pkt_cnt[i*CW +: CW], exp_in[i]);
    end
    chk({tag, "_out_cnt"}, out_pkt_cnt, exp_out);
  endtask

  // Feeder: pops beats that handshook on the last edge, then presents
  // each channel's queue head; handshakes are sampled late in the cycle.
  initial begin
    in_valid = '0;
    in_data  = '0;
    in_sop   = '0;
    in_eop   = '0;
    in_empty = '0;
    hs       = '0;
    forever begin
      @(posedge Clk);
      #2;
      for (int i = 0; i < N; i++) begin
        if (hs[i] && chq[i].size() > 0) void'(chq[i].pop_front());
        if (chq[i].size() > 0) begin
          in_valid[i]          = 1'b1;
          in_data[i*DW +: DW]  = chq[i][0].d;
          in_sop[i]            = chq[i][0].sop;
          in_eop[i]            = chq[i][0].eop;
          in_empty[i*EW +: EW] = chq[i][0].e;
        end else begin
          in_valid[i] = 1'b0;
        end
      end
      #6;
      hs = in_valid & in_ready;
    end
  end

  // Monitor: scoreboard compare on every egress handshake, plus a
  // hold check for each cycle following a stalled output.
  initial begin
    beat_t got;
    beat_t prev;
    beat_t e;
    logic  prev_stall;
    prev_stall = 1'b0;
    prev = '0;
    forever begin
      @(negedge Clk);
      got = {out_data, out_sop, out_eop, out_empty};
      if (Rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          checks++;
          if (!out_valid || got !== prev) begin
            errors++;
            $display("FAIL hold got=%0h v=%0b want=%0h", got,
                     out_valid, prev);
          end
        end
        prev_stall = out_valid && !out_ready;
        prev = got;
        if (out_valid && out_ready) begin
          checks++;
          log_cyc.push_back(cyc);
          if (expq.size() == 0) begin
            errors++;
            $display("FAIL extra_beat got=%0h want=none", got);
          end else begin
            e = expq.pop_front();
            if (got !== e) begin
              errors++;
              $display("FAIL beat got=%0h want=%0h", got, e);
            end
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < N; i++) exp_in[i] = 0;
    Rst = 1'b1;
    out_ready = 1'b1;
    out_almostfull = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_data", out_data, 0);
    check_cnt("rst");
    @(posedge Clk);
    #1;
    Rst = 1'b0;

    // ch0 and ch3 together: ch0 first, one-bubble gap, then ch3
    log_cyc.delete();
    push_pkt(0, 3);
    push_pkt(3, 3);
    drain();
    chk("t1_nbeats", log_cyc.size(), 6);
    if (log_cyc.size() == 6) begin
      chk("t1_b2w", log_cyc[2] - log_cyc[0], 2);
      chk("t1_gap", log_cyc[3] - log_cyc[2], 2);
      chk("t1_b2w_ch3", log_cyc[5] - log_cyc[3], 2);
    end
    check_cnt("t1");

    // 50 single-beat packets, all channels busy; ptr was left at 3
    for (int k = 0; k < 50; k++) begin
`ifdef EGRESS_PRIO_EN
      push_pkt((k < 10) ? 0 : 1 + ((k - 10 + 3) % 4), 1);
`else
      push_pkt((4 + k) % 5, 1);
`endif
    end
    drain();
    check_cnt("t2");

    // egress stall in the middle of a 4-beat packet
    push_pkt(1, 4);
    repeat (3) @(posedge Clk);
    #1;
    out_ready = 1'b0;
    repeat (5) @(posedge Clk);
    #1;
    out_ready = 1'b1;
    drain();
    check_cnt("t3");

    // almostfull raised mid-packet blocks only the next grant
    push_pkt(2, 4);
    repeat (2) @(posedge Clk);
    #1;
    out_almostfull = 1'b1;
    push_pkt(3, 1);
    repeat (12) @(posedge Clk);
    #1;
    chk("t4_af_ready", in_ready, 0);
    chk("t4_af_pending", chq[3].size(), 1);
    out_almostfull = 1'b0;
    @(posedge Clk);
    #1;
    chk("t4_resume", in_ready, 5'b01000);
    drain();
    check_cnt("t4");

    // async reset during beat 2 of a packet
    push_pkt(4, 3);
    repeat (3) @(posedge Clk);
    #3;
    Rst = 1'b1;
    #1;
    chk("t5_out_valid", out_valid, 0);
    chk("t5_out_cnt", out_pkt_cnt, 0);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("t5_in_cnt%0d", i), in_pkt_cnt[i*CW +: CW], 0);
      chq[i].delete();
      exp_in[i] = 0;
    end
    expq.delete();
    exp_out = 0;
    @(posedge Clk);
    #1;
    Rst = 1'b0;
    for (int i = 0; i < N; i++) push_pkt(i, 1);
    drain();
    check_cnt("t5");

    // ch0 and ch2 contending; ptr was left at 4
`ifdef EGRESS_PRIO_EN
    push_pkt(0, 1);
    push_pkt(0, 1);
    push_pkt(0, 1);
    push_pkt(2, 1);
    push_pkt(2, 1);
    push_pkt(2, 1);
`else
    for (int k = 0; k < 3; k++) begin
      push_pkt(0, 1);
      push_pkt(2, 1);
    end
`endif
    drain();
    check_cnt("t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
